// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM states,
// parity encodings and a frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Total clock cycles for one frame; an illegal parity code counts as none.
  function automatic int frame_cycles(input int cpb, input int parity, input int stop_bits);
    int p;
    p = ((parity == PAR_EVEN) || (parity == PAR_ODD)) ? 1 : 0;
    return (1 + 8 + p + stop_bits) * cpb;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// every bit period. Held at zero while clear is asserted.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. tx and tx_busy are registered from the next-state decode.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);

  localparam bit PAR_EN = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam bit PAR_INV = (PARITY == PAR_ODD);
  localparam logic [2:0] LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  uart_state_t state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_d, busy_d;
  logic        bit_done;
  logic        clear;

  // Counter sits at zero in IDLE so the first START cycle is count 0.
  assign clear = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d = tx_data;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // idx_q counts stop bits here.
        if (bit_done) begin
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level decoded from the next state so it changes on the same edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[idx_d];
      ST_PARITY: tx_d = (^shift_d) ^ PAR_INV;
      default:   tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: default, even-parity/2-stop and
// odd-parity instances share the clock, reset and tx_data.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start_v;
  logic [7:0] tx_data;
  logic [2:0] tx_v;
  logic [2:0] busy_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx u_def (
    .clk     (clk),
    .reset   (reset),
    .tx_start(start_v[0]),
    .tx_data (tx_data),
    .tx      (tx_v[0]),
    .tx_busy (busy_v[0])
  );

  uart_tx #(.CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(2)) u_even (
    .clk     (clk),
    .reset   (reset),
    .tx_start(start_v[1]),
    .tx_data (tx_data),
    .tx      (tx_v[1]),
    .tx_busy (busy_v[1])
  );

  uart_tx #(.CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk     (clk),
    .reset   (reset),
    .tx_start(start_v[2]),
    .tx_data (tx_data),
    .tx      (tx_v[2]),
    .tx_busy (busy_v[2])
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Single-cycle start pulse; returns half a cycle after the accepting edge.
  task automatic applyStimulus(input int sel, input logic [7:0] data, input string tag);
    @(negedge clk);
    tx_data      = data;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    checkOutput({tag, " accept busy"}, 32'(busy_v[sel]), 32'd1);
    checkOutput({tag, " accept tx"}, 32'(tx_v[sel]), 32'd0);
  endtask

  // Samples mid-slot line levels and the exact busy fall edge; optionally
  // pulses tx_start with different data partway through the frame.
  task automatic checkFrame(input int sel, input string tag, input string bits,
                            input int glitch_at);
    int total;
    total = bits.len() * 16;
    for (int c = 0; c <= total; c++) begin
      if ((c % 16) == 8)
        checkOutput($sformatf("%s slot%0d", tag, c / 16), 32'(tx_v[sel]),
                    32'(bits.getc(c / 16) == 8'h31));
      if (c == total - 1)
        checkOutput({tag, " busy last cycle"}, 32'(busy_v[sel]), 32'd1);
      if (c == total) begin
        checkOutput({tag, " busy after frame"}, 32'(busy_v[sel]), 32'd0);
        checkOutput({tag, " tx idle after frame"}, 32'(tx_v[sel]), 32'd1);
      end
      if (c == glitch_at) begin
        start_v[sel] = 1'b1;
        tx_data      = 8'hFF;
      end else if (c == glitch_at + 1) begin
        start_v[sel] = 1'b0;
      end
      if (c < total) @(negedge clk);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start_v = '0;
    tx_data = '0;

    #1;
    checkOutput("reset tx", 32'(tx_v), 32'h7);
    checkOutput("reset busy", 32'(busy_v), 32'h0);
    #10;
    checkOutput("reset tx mid", 32'(tx_v), 32'h7);
    checkOutput("reset busy mid", 32'(busy_v), 32'h0);
    #9;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("idle tx", 32'(tx_v), 32'h7);
      checkOutput("idle busy", 32'(busy_v), 32'h0);
    end

    applyStimulus(0, 8'hA5, "def A5");
    checkFrame(0, "def A5", "0101001011", -1);

    repeat (10) @(negedge clk);
    applyStimulus(0, 8'h3C, "def 3C");
    checkFrame(0, "def 3C", "0001111001", -1);

    applyStimulus(1, 8'hA5, "even A5");
    checkFrame(1, "even A5", "010100101011", -1);

    applyStimulus(2, 8'h3C, "odd 3C");
    checkFrame(2, "odd 3C", "00011110011", -1);

    applyStimulus(0, 8'hA5, "ignore");
    checkFrame(0, "ignore", "0101001011", 40);

    // Level-held start: next frame accepted one cycle after busy falls.
    @(negedge clk);
    tx_data    = 8'h3C;
    start_v[0] = 1'b1;
    @(negedge clk);
    checkOutput("held accept busy", 32'(busy_v[0]), 32'd1);
    repeat (159) @(negedge clk);
    checkOutput("held busy last", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    checkOutput("held gap busy", 32'(busy_v[0]), 32'd0);
    checkOutput("held gap tx", 32'(tx_v[0]), 32'd1);
    @(negedge clk);
    checkOutput("held reaccept busy", 32'(busy_v[0]), 32'd1);
    checkOutput("held reaccept tx", 32'(tx_v[0]), 32'd0);
    start_v[0] = 1'b0;
    repeat (165) @(negedge clk);
    checkOutput("held done busy", 32'(busy_v[0]), 32'd0);

    // Reset in the middle of data bit 3 (a 0 for A5).
    applyStimulus(0, 8'hA5, "rst A5");
    repeat (70) @(negedge clk);
    checkOutput("pre-reset tx", 32'(tx_v[0]), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("async reset tx", 32'(tx_v[0]), 32'd1);
    checkOutput("async reset busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post-reset busy", 32'(busy_v[0]), 32'd0);
    applyStimulus(0, 8'h3C, "post-reset 3C");
    checkFrame(0, "post-reset 3C", "0001111001", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
